// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stage enables/flushes, load-use and
// branch hazards, memory-wait freezes, HLT drain/halt and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_opcode,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [3:0]       id_ex_opcode,
    input  logic [3:0]       id_ex_rd,
    input  logic             ex_branch_taken,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam int         DW     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   drain_cnt, drain_cnt_nxt;
    logic            stall_inc, flush_inc;
    logic            load_use;

    // Only a load still in EX can miss forwarding; r0 is never a real hazard.
    assign load_use = (id_ex_opcode == OP_LW) && (id_ex_rd != 4'd0) &&
                      ((id_uses_rs && (id_rs == id_ex_rd)) ||
                       (id_uses_rt && (id_rt == id_ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RESET;
            drain_cnt    <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            if (stall_inc && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
            if (flush_inc && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        pc_we         = 1'b0;
        if_id_we      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_we      = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_we     = 1'b0;
        mem_wb_we     = 1'b0;
        mem_wb_flush  = 1'b0;
        halted        = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        case (state)
            ST_RESET: begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                mem_wb_flush = 1'b1;
                state_nxt    = ST_RUN;
            end

            ST_RUN: begin
                pc_we     = 1'b1;
                if_id_we  = 1'b1;
                id_ex_we  = 1'b1;
                ex_mem_we = 1'b1;
                mem_wb_we = 1'b1;
                if (dmem_busy) begin
                    // EX is frozen too, so a taken branch will be re-presented.
                    pc_we     = 1'b0;
                    if_id_we  = 1'b0;
                    id_ex_we  = 1'b0;
                    ex_mem_we = 1'b0;
                    mem_wb_we = 1'b0;
                    stall_inc = 1'b1;
                end else if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_inc   = 1'b1;
                end else if (imem_busy || load_use) begin
                    pc_we       = 1'b0;
                    if_id_we    = 1'b0;
                    id_ex_flush = 1'b1;
                    stall_inc   = 1'b1;
                end else if (id_opcode == OP_HLT) begin
                    pc_we         = 1'b0;
                    if_id_flush   = 1'b1;
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = DRAIN_LAST;
                end
            end

            ST_DRAIN: begin
                if (dmem_busy) begin
                    stall_inc = 1'b1;
                end else if (ex_branch_taken) begin
                    // HLT was on the wrong path: squash it and resume.
                    pc_we       = 1'b1;
                    if_id_we    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_we    = 1'b1;
                    id_ex_flush = 1'b1;
                    ex_mem_we   = 1'b1;
                    mem_wb_we   = 1'b1;
                    flush_inc   = 1'b1;
                    state_nxt   = ST_RUN;
                end else begin
                    if_id_we    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_we    = 1'b1;
                    id_ex_flush = (drain_cnt != DRAIN_LAST);
                    ex_mem_we   = 1'b1;
                    mem_wb_we   = 1'b1;
                    if (drain_cnt == '0)
                        state_nxt = ST_HALTED;
                    else
                        drain_cnt_nxt = drain_cnt - 1'b1;
                end
            end

            ST_HALTED: begin
                halted = 1'b1;
            end

            default: state_nxt = ST_RESET;
        endcase
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a rule-level reference model checked every
// cycle, plus hand-computed literal expectations at key points of each scenario.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W     = 4;
    localparam int DRAIN_CYC = 3;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Model phases and per-cycle actions.
    localparam int P_RESET = 0, P_RUN = 1, P_DRAIN = 2, P_HALTED = 3;
    localparam int A_IDLE = 0, A_NORMAL = 1, A_FREEZE = 2, A_REDIRECT = 3,
                   A_BUBBLE = 4, A_HLT_ENTRY = 5, A_DRAIN_STEP = 6, A_RESET = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       id_opcode, id_rs, id_rt, id_ex_opcode, id_ex_rd;
    logic             id_uses_rs, id_uses_rt, ex_branch_taken, imem_busy, dmem_busy;
    logic             pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
    logic             ex_mem_we, mem_wb_we, mem_wb_flush, halted;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    int m_phase     = P_RESET;
    int m_drain_idx = 0;
    int m_stall     = 0;
    int m_flush     = 0;

    typedef struct packed {
        logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
        logic ex_mem_we, mem_wb_we, mem_wb_flush, halted;
    } ctl_t;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_ex_opcode(id_ex_opcode), .id_ex_rd(id_ex_rd),
        .ex_branch_taken(ex_branch_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we),
        .mem_wb_we(mem_wb_we), .mem_wb_flush(mem_wb_flush), .halted(halted),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int pick_action();
        logic lu;
        lu = (id_ex_opcode == OP_LW) && (id_ex_rd != 0) &&
             ((id_uses_rs && id_rs == id_ex_rd) || (id_uses_rt && id_rt == id_ex_rd));
        if (m_phase == P_RESET)  return A_RESET;
        if (m_phase == P_HALTED) return A_IDLE;
        if (dmem_busy)           return A_FREEZE;
        if (ex_branch_taken)     return A_REDIRECT;
        if (m_phase == P_DRAIN)  return A_DRAIN_STEP;
        if (imem_busy || lu)     return A_BUBBLE;
        if (id_opcode == OP_HLT) return A_HLT_ENTRY;
        return A_NORMAL;
    endfunction

    function automatic ctl_t expect_ctl(input int act);
        ctl_t c;
        c = '0;
        case (act)
            A_RESET:      begin c.if_id_flush = 1; c.id_ex_flush = 1; c.mem_wb_flush = 1; end
            A_IDLE:       c.halted = 1;
            A_FREEZE:     c = '0;
            A_NORMAL:     c = '{1, 1, 0, 1, 0, 1, 1, 0, 0};
            A_REDIRECT:   c = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
            A_BUBBLE:     c = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
            A_HLT_ENTRY:  c = '{0, 1, 1, 1, 0, 1, 1, 0, 0};
            A_DRAIN_STEP: begin
                c = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
                c.id_ex_flush = (m_drain_idx != 0);
            end
            default:      c = '0;
        endcase
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase     <= P_RESET;
            m_drain_idx <= 0;
            m_stall     <= 0;
            m_flush     <= 0;
        end else begin
            case (pick_action())
                A_RESET:     m_phase <= P_RUN;
                A_FREEZE,
                A_BUBBLE:    m_stall <= (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
                A_REDIRECT: begin
                    m_flush <= (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
                    m_phase <= P_RUN;
                end
                A_HLT_ENTRY: begin m_phase <= P_DRAIN; m_drain_idx <= 0; end
                A_DRAIN_STEP: begin
                    if (m_drain_idx == DRAIN_CYC - 1) m_phase <= P_HALTED;
                    else m_drain_idx <= m_drain_idx + 1;
                end
                default: ;
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        ctl_t e;
        e = expect_ctl(pick_action());
        chk("pc_we",        32'(pc_we),        32'(e.pc_we));
        chk("if_id_we",     32'(if_id_we),     32'(e.if_id_we));
        chk("if_id_flush",  32'(if_id_flush),  32'(e.if_id_flush));
        chk("id_ex_we",     32'(id_ex_we),     32'(e.id_ex_we));
        chk("id_ex_flush",  32'(id_ex_flush),  32'(e.id_ex_flush));
        chk("ex_mem_we",    32'(ex_mem_we),    32'(e.ex_mem_we));
        chk("mem_wb_we",    32'(mem_wb_we),    32'(e.mem_wb_we));
        chk("mem_wb_flush", 32'(mem_wb_flush), 32'(e.mem_wb_flush));
        chk("halted",       32'(halted),       32'(e.halted));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        chk("flush_count",  32'(flush_count),  32'(m_flush));
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        id_opcode = OP_NOP; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_ex_opcode = OP_NOP; id_ex_rd = 0;
        ex_branch_taken = 0; imem_busy = 0; dmem_busy = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic [3:0] rd, input logic via_rt);
        id_ex_opcode = OP_LW; id_ex_rd = rd;
        if (via_rt) begin id_rt = rd; id_uses_rt = 1; end
        else        begin id_rs = rd; id_uses_rs = 1; end
    endtask

    task automatic do_reset();
        rst_n = 0;
        step(1);
        rst_n = 1;
        step(1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("lit_reset_pc_we",     32'(pc_we), 0);
        chk("lit_reset_if_flush",  32'(if_id_flush), 1);
        chk("lit_reset_wb_flush",  32'(mem_wb_flush), 1);
        chk("lit_reset_stall",     32'(stall_cycles), 0);
        rst_n = 1;
        step(1);
        chk("lit_run_pc_we",       32'(pc_we), 1);
        chk("lit_run_mem_wb_we",   32'(mem_wb_we), 1);

        // Load-use via Rs, then r0 destination, then via Rt.
        set_load_use(4'd3, 1'b0);
        #1;
        chk("lit_lu_pc_we",        32'(pc_we), 0);
        chk("lit_lu_id_ex_flush",  32'(id_ex_flush), 1);
        step(1); set_idle();
        chk("lit_lu_stall",        32'(stall_cycles), 1);
        set_load_use(4'd0, 1'b0);
        #1;
        chk("lit_lu_r0_pc_we",     32'(pc_we), 1);
        step(1); set_idle();
        chk("lit_lu_r0_stall",     32'(stall_cycles), 1);
        set_load_use(4'd5, 1'b1);
        step(1); set_idle();
        chk("lit_lu_rt_stall",     32'(stall_cycles), 2);

        // Taken branch beats a simultaneous load-use.
        set_load_use(4'd3, 1'b0);
        ex_branch_taken = 1;
        #1;
        chk("lit_br_pc_we",        32'(pc_we), 1);
        chk("lit_br_if_flush",     32'(if_id_flush), 1);
        chk("lit_br_id_ex_flush",  32'(id_ex_flush), 1);
        step(1); set_idle();
        chk("lit_br_flush_cnt",    32'(flush_count), 1);
        chk("lit_br_stall",        32'(stall_cycles), 2);

        // dmem wait with a pending branch: frozen, branch counted only on release.
        dmem_busy = 1; ex_branch_taken = 1;
        step(4);
        chk("lit_dm_flush_held",   32'(flush_count), 1);
        chk("lit_dm_stall",        32'(stall_cycles), 6);
        dmem_busy = 0;
        step(1); set_idle();
        chk("lit_dm_flush_rel",    32'(flush_count), 2);

        // Plain HLT: entry, three drain cycles, halted.
        id_opcode = OP_HLT;
        #1;
        chk("lit_hlt_entry_pc_we", 32'(pc_we), 0);
        chk("lit_hlt_entry_ifl",   32'(if_id_flush), 1);
        chk("lit_hlt_entry_idexf", 32'(id_ex_flush), 0);
        step(1); set_idle();
        chk("lit_drain1_idexf",    32'(id_ex_flush), 0);
        step(1);
        chk("lit_drain2_idexf",    32'(id_ex_flush), 1);
        chk("lit_drain2_halted",   32'(halted), 0);
        step(2);
        chk("lit_halted",          32'(halted), 1);
        chk("lit_halted_ex_we",    32'(ex_mem_we), 0);
        chk("lit_halt_stall",      32'(stall_cycles), 6);
        step(3);
        chk("lit_halted_stays",    32'(halted), 1);

        // Reset asserted in the middle of DRAIN.
        do_reset();
        id_opcode = OP_HLT;
        step(1); set_idle();
        #3; rst_n = 0; #1;
        chk("lit_mid_rst_pc_we",   32'(pc_we), 0);
        chk("lit_mid_rst_idexf",   32'(id_ex_flush), 1);
        chk("lit_mid_rst_halted",  32'(halted), 0);
        chk("lit_mid_rst_stall",   32'(stall_cycles), 0);
        chk("lit_mid_rst_flush",   32'(flush_count), 0);
        step(1);
        rst_n = 1;
        step(1);
        chk("lit_post_rst_pc_we",  32'(pc_we), 1);

        // HLT with dmem_busy holding the first drain cycle for two cycles.
        id_opcode = OP_HLT;
        step(1); set_idle();
        dmem_busy = 1;
        step(2);
        dmem_busy = 0;
        #1;
        chk("lit_dmdrain_idexf",   32'(id_ex_flush), 0);
        step(2);
        chk("lit_dmdrain_pending", 32'(halted), 0);
        step(1);
        chk("lit_dmdrain_halted",  32'(halted), 1);
        chk("lit_dmdrain_stall",   32'(stall_cycles), 2);

        // Wrong-path HLT squashed by a branch on the second drain cycle.
        do_reset();
        id_opcode = OP_HLT;
        step(1); set_idle();
        step(1);
        ex_branch_taken = 1;
        #1;
        chk("lit_wp_pc_we",        32'(pc_we), 1);
        chk("lit_wp_idexf",        32'(id_ex_flush), 1);
        step(1); set_idle();
        chk("lit_wp_flush_cnt",    32'(flush_count), 1);
        chk("lit_wp_run_pc_we",    32'(pc_we), 1);
        step(4);
        chk("lit_wp_not_halted",   32'(halted), 0);

        // Counter saturation at all-ones.
        imem_busy = 1;
        step(17);
        chk("lit_sat_stall",       32'(stall_cycles), CNT_MAX);
        imem_busy = 0;
        set_load_use(4'd7, 1'b0);
        step(1); set_idle();
        chk("lit_sat_stall_hold",  32'(stall_cycles), CNT_MAX);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage 16-bit core (IF, ID, EX, MEM, WB).
- Drives write-enable and flush (bubble) controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards not covered by forwarding, squashes wrong-path instructions on taken branches, and freezes on multi-cycle memory waits.
- Sequences HLT drain and halt, and keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of performance counters
- DRAIN_CYC, 3, cycles from HLT leaving ID until it retires from WB

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- id_opcode  input  4  opcode of instruction in ID
- id_rs  input  4  Rs of instruction in ID
- id_rt  input  4  Rt of instruction in ID
- id_uses_rs  input  1  ID instruction reads Rs
- id_uses_rt  input  1  ID instruction reads Rt
- id_ex_opcode  input  4  opcode in ID/EX register
- id_ex_rd  input  4  destination in ID/EX register
- ex_branch_taken  input  1  branch/BR resolved taken in EX this cycle
- imem_busy  input  1  instruction memory not ready
- dmem_busy  input  1  data memory access in MEM not complete
- pc_we  output  1  PC update enable
- if_id_we  output  1  IF/ID write enable
- if_id_flush  output  1  load NOP into IF/ID
- id_ex_we  output  1  ID/EX write enable
- id_ex_flush  output  1  load NOP into ID/EX
- ex_mem_we  output  1  EX/MEM write enable
- mem_wb_we  output  1  MEM/WB write enable
- mem_wb_flush  output  1  load NOP into MEM/WB
- halted  output  1  core halted
- stall_cycles  output  CNT_W  saturating count of frozen-fetch cycles
- flush_count  output  CNT_W  saturating count of taken-branch flushes

Behaviour:
- Opcodes: LW=4'b1000, SW=4'b1001, HLT=4'b1111.
- States: RESET, RUN, DRAIN, HALTED. rst_n low forces RESET asynchronously, clears counters and the drain counter. RESET goes to RUN on the first clk edge after deassertion.
- Outputs are combinational from state and inputs; state and counters are registered.
- A flush takes precedence over the matching we of the same register. Flush asserts imply the stage write occurs with NOP.
- RESET: all *_we=0, if_id_flush=id_ex_flush=mem_wb_flush=1, halted=0.
- RUN default: all we=1, all flush=0.
- RUN priority, highest first:
  1. dmem_busy: all we=0, no flush; whole pipe frozen.
  2. ex_branch_taken: pc_we=1 (redirect), if_id_flush=1, id_ex_flush=1. Any load-use condition in the same cycle is ignored.
  3. imem_busy: pc_we=0, if_id_we=0, id_ex_flush=1.
  4. Load-use: id_ex_opcode==LW, id_ex_rd!=0, and ((id_uses_rs & id_rs==id_ex_rd) | (id_uses_rt & id_rt==id_ex_rd)). Response: pc_we=0, if_id_we=0, id_ex_flush=1. Exactly one bubble is inserted, because the next cycle the LW is in MEM and the rule no longer matches.
- HLT entry: in RUN with id_opcode==HLT and rules 1–4 inactive, the HLT advances into ID/EX. At the same time pc_we=0 and if_id_flush=1. Next state is DRAIN, with the drain counter set to DRAIN_CYC-1.
- DRAIN:
  - pc_we=0, if_id_flush=1.
  - id_ex_flush=0 on the first DRAIN cycle (HLT already latched), 1 afterwards.
  - ex_mem_we=mem_wb_we=1.
  - dmem_busy freezes all we and holds the drain counter.
  - ex_branch_taken in DRAIN means the HLT is wrong-path: apply the rule-2 outputs, return to RUN, and count the flush.
  - When the counter reaches 0, go to HALTED.
- HALTED: all we=0, flushes 0, halted=1; exit only by reset.
- stall_cycles increments, saturating at all-ones, on each RUN/DRAIN cycle with pc_we=0 not caused by HLT entry or DRAIN.
- flush_count increments, saturating, on each cycle ex_branch_taken is honoured (RUN or DRAIN, not under dmem_busy). Under dmem_busy, ex_branch_taken is ignored, because EX is frozen and re-presents the branch.

Test Plan:
- Reset: hold rst_n=0 mid-DRAIN -> immediately RESET outputs (we=0, flushes=1, halted=0), counters 0. One clk after release -> RUN, all we=1.
- Load-use: id_ex_opcode=LW, id_ex_rd=3, id_rs=3, id_uses_rs=1 -> one cycle pc_we=0, if_id_we=0, id_ex_flush=1; stall_cycles=1. Same case with id_ex_rd=0 -> no stall.
- Branch vs load-use: ex_branch_taken=1 together with the load-use match -> pc_we=1, if_id_flush=id_ex_flush=1; flush_count=1, stall_cycles unchanged.
- dmem_busy held 4 cycles while ex_branch_taken=1 -> all we=0 for 4 cycles, flush_count unchanged; on release, one flush counted.
- HLT: id_opcode=HLT, no hazards -> DRAIN for 3 cycles, then halted=1 with all we=0. Repeat with dmem_busy for 2 DRAIN cycles -> halted 2 cycles later.
- Wrong-path HLT: ex_branch_taken=1 on the 2nd DRAIN cycle -> back to RUN, halted stays 0, flush_count+1.
